matrix_bus_regfile: RTL and testbench

- Memory-mapped register bank between the host bus and an NxN complex matrix multiplier.
- Holds operand matrices A and B and a captured copy of result matrix C.
- Provides control, status and cycle-count registers, and sequences one multiply per start command.
- Reads are registered with a valid strobe. The flattened operand and result buses connect directly to the multiplier core.

---
 rtl/matrix_bus_regfile.sv | 165 ++++++++++++++++
 tb/tb_matrix_bus_regfile.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_bus_regfile.sv
// Host-bus register bank for an NxN complex matrix multiplier: holds operands A/B,
// captures result C, and sequences one multiply per start command.
module matrix_bus_regfile #(
  parameter int N     = 4,
  parameter int Width = 8,
  parameter int DW    = 32,
  parameter int AW    = 9
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Write,
  input  logic                     Read,
  input  logic [AW-1:0]            Address,
  input  logic [DW-1:0]            WrData,
  output logic [DW-1:0]            RdData,
  output logic                     RdValid,
  output logic [2*N*N*Width-1:0]   OpA,
  output logic [2*N*N*Width-1:0]   OpB,
  output logic                     MulStart,
  input  logic                     MulDone,
  input  logic [2*N*N*Width-1:0]   Result,
  output logic                     Busy
);

  localparam int unsigned NW = 2 * N * N;
  localparam int unsigned R  = 8 * N * N;
  localparam int unsigned IW = $clog2(NW);

  localparam logic [AW-1:0] B_BASE      = AW'(R);
  localparam logic [AW-1:0] C_BASE      = AW'(2 * R);
  localparam logic [AW-1:0] CTRL_ADDR   = AW'(3 * R);
  localparam logic [AW-1:0] STATUS_ADDR = AW'(3 * R + 4);
  localparam logic [AW-1:0] CYCLES_ADDR = AW'(3 * R + 8);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [Width-1:0]  a_q [NW];
  logic [Width-1:0]  a_d [NW];
  logic [Width-1:0]  b_q [NW];
  logic [Width-1:0]  b_d [NW];
  logic [Width-1:0]  c_q [NW];
  logic [Width-1:0]  c_d [NW];
  logic              err_q, err_d;
  logic [DW-1:0]     cycles_q, cycles_d;
  logic [DW-1:0]     rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              mul_start_q, mul_start_d;

  logic              aligned, hit_a, hit_b, hit_c, hit_ctrl, hit_status, hit_cycles;
  logic [AW-1:0]     off;
  logic [IW-1:0]     idx;
  logic              busy, done, start_req;
  logic              unused_bits;

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign unused_bits = ^{WrData, off};

  // Word offset within a region maps 1:1 onto the flat-bus slot (real/imag interleaved).
  always_comb begin
    aligned    = (Address[1:0] == 2'b00);
    hit_a      = aligned && (Address < B_BASE);
    hit_b      = aligned && (Address >= B_BASE) && (Address < C_BASE);
    hit_c      = aligned && (Address >= C_BASE) && (Address < CTRL_ADDR);
    hit_ctrl   = (Address == CTRL_ADDR);
    hit_status = (Address == STATUS_ADDR);
    hit_cycles = (Address == CYCLES_ADDR);
    if (hit_b)      off = Address - B_BASE;
    else if (hit_c) off = Address - C_BASE;
    else            off = Address;
    idx = off[IW+1:2];
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    err_d       = err_q;
    cycles_d    = cycles_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = Read;
    mul_start_d = 1'b0;
    start_req   = Write && hit_ctrl && WrData[0];

    // Reads see pre-edge state; the STATUS err clear precedes any new err set below.
    if (Read) begin
      rd_data_d = '0;
      if (hit_a)           rd_data_d = DW'($signed(a_q[idx]));
      else if (hit_b)      rd_data_d = DW'($signed(b_q[idx]));
      else if (hit_c)      rd_data_d = DW'($signed(c_q[idx]));
      else if (hit_cycles) rd_data_d = cycles_q;
      else if (hit_status) begin
        rd_data_d = DW'({err_q, done, busy});
        err_d     = 1'b0;
      end
    end

    if (busy && (cycles_q != '1)) cycles_d = cycles_q + DW'(1);

    if (Write && (hit_a || hit_b)) begin
      if (busy)       err_d       = 1'b1;
      else if (hit_a) a_d[idx]    = WrData[Width-1:0];
      else            b_d[idx]    = WrData[Width-1:0];
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_req) begin
          state_d     = S_RUN;
          mul_start_d = 1'b1;
          cycles_d    = '0;
        end
      end
      S_RUN: begin
        if (start_req) err_d = 1'b1;
        if (MulDone) begin
          state_d = S_DONE;
          for (int unsigned k = 0; k < NW; k++) c_d[k] = Result[k*Width +: Width];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      a_q         <= '{default: '0};
      b_q         <= '{default: '0};
      c_q         <= '{default: '0};
      err_q       <= 1'b0;
      cycles_q    <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      mul_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      err_q       <= err_d;
      cycles_q    <= cycles_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      mul_start_q <= mul_start_d;
    end
  end

  always_comb begin
    OpA = '0;
    OpB = '0;
    for (int unsigned k = 0; k < NW; k++) begin
      OpA[k*Width +: Width] = a_q[k];
      OpB[k*Width +: Width] = b_q[k];
    end
  end

  assign RdData   = rd_data_q;
  assign RdValid  = rd_valid_q;
  assign MulStart = mul_start_q;
  assign Busy     = busy;

endmodule

// File: tb/tb_matrix_bus_regfile.sv
// Directed bench for matrix_bus_regfile: read results go through a due-cycle scoreboard,
// control outputs are checked inline.
module tb_matrix_bus_regfile;

  localparam int N = 4, Width = 8, DW = 32, AW = 9;
  localparam int FW = 2 * N * N * Width;

  localparam logic [AW-1:0] CTRL   = 9'h180;
  localparam logic [AW-1:0] STATUS = 9'h184;
  localparam logic [AW-1:0] CYCLES = 9'h188;

  logic          Clk = 1'b0;
  logic          Reset, Write, Read, MulDone;
  logic [AW-1:0] Address;
  logic [DW-1:0] WrData;
  logic [DW-1:0] RdData;
  logic          RdValid, MulStart, Busy;
  logic [FW-1:0] OpA, OpB, Result;

  matrix_bus_regfile #(.N(N), .Width(Width), .DW(DW), .AW(AW)) dut (
    .Clk(Clk), .Reset(Reset), .Write(Write), .Read(Read), .Address(Address),
    .WrData(WrData), .RdData(RdData), .RdValid(RdValid), .OpA(OpA), .OpB(OpB),
    .MulStart(MulStart), .MulDone(MulDone), .Result(Result), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   due;
    string         tag;
  } sb_t;

  sb_t         sb[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  int unsigned ms_cnt = 0;

  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    if (cyc > 0) begin
      logic exp_v;
      sb_t  e;
      exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      ms_cnt += (MulStart === 1'b1) ? 1 : 0;
      checks++;
      assert (RdValid === exp_v) else begin
        errors++;
        $error("FAIL rd_valid: observed=%b expected=%b cycle=%0d", RdValid, exp_v, cyc);
      end
      if (exp_v) begin
        e = sb.pop_front();
        checks++;
        assert (RdData === e.data) else begin
          errors++;
          $error("FAIL %s: observed=%h expected=%h", e.tag, RdData, e.data);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    Write = 1'b1; Address = a; WrData = d;
    tick();
    Write = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    Read = 1'b1; Address = a;
    sb.push_back('{data: exp, due: cyc + 1, tag: tag});
    tick();
    Read = 1'b0;
  endtask

  task automatic rdwr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] exp, input string tag);
    Read = 1'b1; Write = 1'b1; Address = a; WrData = d;
    sb.push_back('{data: exp, due: cyc + 1, tag: tag});
    tick();
    Read = 1'b0; Write = 1'b0;
  endtask

  initial begin
    int unsigned pulses_before;
    Reset = 1'b1; Write = 1'b0; Read = 1'b0; MulDone = 1'b0;
    Address = '0; WrData = '0; Result = '0;
    repeat (3) tick();
    Reset = 1'b0;

    chk("reset_rddata", RdData, 32'h0);
    chk("reset_mulstart", {31'b0, MulStart}, 32'h0);
    chk("reset_busy", {31'b0, Busy}, 32'h0);
    chk("reset_opa", {31'b0, |OpA}, 32'h0);
    rd(STATUS, 32'h0, "reset_status");
    rd(CYCLES, 32'h0, "reset_cycles");

    // Operand writes: truncation, sign extension, flat packing
    wr(9'h004, 32'h0000_01FF);
    chk("opa_e0_imag", {24'b0, OpA[15:8]}, 32'h0000_00FF);
    rd(9'h004, 32'hFFFF_FFFF, "rd_a_e0_imag");
    wr(9'h088, 32'h0000_007F);
    chk("opb_e1_real", {24'b0, OpB[23:16]}, 32'h0000_007F);
    rd(9'h088, 32'h0000_007F, "rd_b_e1_real");
    wr(9'h080, 32'h1234_5680);
    chk("opb_e0_real", {24'b0, OpB[7:0]}, 32'h0000_0080);
    rd(9'h080, 32'hFFFF_FF80, "rd_b_e0_real");
    rdwr(9'h008, 32'h0000_0055, 32'h0, "rdwr_pre_value");
    rd(9'h008, 32'h0000_0055, "rdwr_post_value");
    wr(CTRL, 32'h0);
    chk("ctrl0_busy", {31'b0, Busy}, 32'h0);
    chk("ctrl0_mulstart", {31'b0, MulStart}, 32'h0);

    // Start, RUN for 10 cycles, complete
    wr(CTRL, 32'h1);
    chk("start_mulstart", {31'b0, MulStart}, 32'h1);
    chk("start_busy", {31'b0, Busy}, 32'h1);
    rd(STATUS, 32'h1, "status_run");
    chk("mulstart_single", {31'b0, MulStart}, 32'h0);
    wr(9'h000, 32'h0000_00AA);
    rd(STATUS, 32'h5, "status_err");
    rd(STATUS, 32'h1, "status_err_cleared");
    rd(9'h000, 32'h0, "run_write_dropped");
    rd(CYCLES, 32'd5, "cycles_mid_run");
    repeat (3) tick();
    Result = '0;
    Result[7:0] = 8'hFD;
    Result[31*Width +: Width] = 8'h44;
    MulDone = 1'b1;
    rd(STATUS, 32'h1, "status_at_muldone");
    MulDone = 1'b0;
    chk("done_busy", {31'b0, Busy}, 32'h0);
    rd(9'h100, 32'hFFFF_FFFD, "c_e0_real");
    rd(9'h17C, 32'h0000_0044, "c_e15_imag");
    rd(STATUS, 32'h2, "status_done");
    rd(CYCLES, 32'd10, "cycles_final");

    // MulDone outside RUN is ignored
    Result[7:0] = 8'h21;
    MulDone = 1'b1;
    tick();
    MulDone = 1'b0;
    rd(9'h100, 32'hFFFF_FFFD, "c_muldone_ignored");

    // Back-to-back starts
    pulses_before = ms_cnt;
    wr(CTRL, 32'h1);
    wr(CTRL, 32'h1);
    rd(STATUS, 32'h5, "status_double_start");
    rd(CYCLES, 32'd2, "cycles_restart");
    chk("one_pulse", ms_cnt - pulses_before, 32'd1);
    MulDone = 1'b1;
    tick();
    MulDone = 1'b0;

    // Misaligned / unmapped / read-only accesses
    rd(9'h002, 32'h0, "misaligned");
    rd(9'h1FC, 32'h0, "unmapped");
    wr(9'h100, 32'h0000_0011);
    rd(9'h100, 32'h0000_0021, "c_readonly");
    rd(CTRL, 32'h0, "ctrl_reads_zero");
    rd(STATUS, 32'h2, "status_done2");

    // Reset mid-RUN with MulDone in and after the reset cycle
    wr(CTRL, 32'h1);
    tick();
    Reset = 1'b1; MulDone = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    MulDone = 1'b0;
    chk("rst_busy", {31'b0, Busy}, 32'h0);
    chk("rst_mulstart", {31'b0, MulStart}, 32'h0);
    chk("rst_opa", {31'b0, |OpA}, 32'h0);
    chk("rst_opb", {31'b0, |OpB}, 32'h0);
    rd(9'h100, 32'h0, "rst_c_zero");
    rd(STATUS, 32'h0, "rst_status");
    rd(CYCLES, 32'h0, "rst_cycles");
    rd(9'h004, 32'h0, "rst_a_zero");

    tick();
    tick();
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
